adc_result_fifo: RTL
====================

Name: adc_result_fifo

Overview:
- Downstream consumer of the SAR ADC controller outputs.
- Detects each end-of-conversion pulse (eoc) and captures the 8-bit conversion result (dout).
- Buffers results in a small synchronous FIFO and presents them on a valid/ready stream to the digital back end (scan chain, wishbone bridge or logic analyzer tap).
- Runs on the same system clock as the SAR logic and flags lost samples with a sticky overflow bit.

Parameters:
- DW, 8: result width; must match the ADC dout width.
- DEPTH, 8: FIFO entries; power of 2, minimum 2.
- AVG_LOG2, 2: log2 of the averaging block size; used only when ADC_AVG_EN is defined.

Ports:
- clk  input  1: system clock, same clock as the SAR logic.
- rst_n  input  1: synchronous active-low reset.
- en  input  1: capture enable, same enable that drives the ADC controller.
- eoc  input  1: end-of-conversion from the SAR logic, level signal in the clk domain.
- din  input  DW: conversion result (ADC dout); valid in the cycle eoc rises.
- clr_ovf  input  1: clears the sticky overflow flag.
- m_ready  input  1: consumer ready.
- m_valid  output  1: FIFO non-empty.
- m_data  output  DW: head-of-FIFO result.
- level  output  $clog2(DEPTH)+1: current occupancy, range 0..DEPTH.
- overflow  output  1: sticky, set when a result is dropped.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - wr_ptr=0, rd_ptr=0, level=0, m_valid=0, overflow=0.
  - eoc_q=1, so an eoc already high at reset release is not treated as a rising edge.
  - m_data reads 0 while empty.
  - FIFO memory is not reset.
  - Reset mid-operation discards all buffered data in the same edge.
- Edge detect:
  - eoc_q <= eoc every cycle, regardless of en.
  - capture = en & eoc & ~eoc_q.
  - din is sampled on the same edge that sees the capture condition.
  - With en held low, eoc_q keeps tracking eoc, so raising en while eoc is high produces no capture.
- Push:
  - Without ADC_AVG_EN, push = capture.
  - Data is written to mem[wr_ptr] and wr_ptr increments with wrap modulo DEPTH.
- Latency:
  - eoc rise sampled at edge N -> m_valid=1 and m_data=din after edge N (1 cycle).
- Pop:
  - pop = m_valid & m_ready.
  - rd_ptr increments with wrap.
  - m_data is show-ahead: combinational from mem[rd_ptr] and always the head entry.
  - m_data is held stable while m_valid=1 and m_ready=0.
- Occupancy:
  - level += push_accepted - pop.
  - m_valid = (level != 0).
- Full (level=DEPTH):
  - push with a simultaneous pop: the push is accepted and level stays DEPTH.
  - push without a pop: the sample is dropped, memory is untouched, and overflow is set at that edge.
- Empty: m_ready is ignored and level does not underflow.
- Simultaneous push and pop when level=0: no pop occurs; the push is accepted and level becomes 1.
- overflow:
  - Cleared by clr_ovf=1.
  - If a drop and clr_ovf occur in the same cycle, overflow=1 (set wins).
- en low:
  - Stops new captures only.
  - Buffered data remains poppable.

Optional Feature:
- Macro: ADC_AVG_EN.
- Defined:
  - Captures feed an accumulator acc of width DW+AVG_LOG2 and a sample counter cnt of width AVG_LOG2.
  - On the capture that completes 2^AVG_LOG2 samples, push (acc+din)>>AVG_LOG2 (truncated), then clear acc and cnt.
  - Other captures only accumulate.
  - en low clears acc and cnt synchronously.
  - Reset clears both.
  - Full and overflow rules apply to the averaged push only.
- Not defined: no accumulator logic; every capture is pushed directly.

Test Plan:
- Reset with eoc held high, release rst_n and en=1, hold eoc high for 5 cycles -> no push, level=0, m_valid=0.
- en=1, m_ready=0, three eoc pulses with din=0x12, 0x34, 0x56 -> level=3, m_data=0x12; then m_ready=1 for 3 cycles -> m_data sequence 0x12, 0x34, 0x56, level=0, m_valid=0.
- DEPTH=8, m_ready=0, 9 eoc pulses with din=1..9 -> level=8, overflow=1, drained data is 1..8 (9 dropped); clr_ovf pulse -> overflow=0.
- FIFO full, m_ready=1 in the same cycle as an eoc rise with din=0xAA -> level stays 8, 0xAA is stored last, overflow=0.
- en=0 during 2 eoc pulses, then en raised while eoc is high -> no captures; existing entries still drain.
- ADC_AVG_EN, AVG_LOG2=2: captures 10, 20, 30, 41 -> single push of 25; 3 more captures -> level unchanged at 1.

Source files
------------

// File: rtl/adc_result_fifo.sv
// Captures ADC results on each rising eoc and buffers them in a show-ahead FIFO
// with a valid/ready output and a sticky overflow flag. Optional averaging: ADC_AVG_EN.
module adc_result_fifo #(
    parameter int DW       = 8,
    parameter int DEPTH    = 8,
    parameter int AVG_LOG2 = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic                     eoc,
    input  logic [DW-1:0]            din,
    input  logic                     clr_ovf,
    input  logic                     m_ready,
    output logic                     m_valid,
    output logic [DW-1:0]            m_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow
);

    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   level_q, level_d;
    logic          overflow_q, overflow_d;
    logic          eoc_q;
    logic [DW-1:0] mem [DEPTH];

    logic          capture;
    logic          push;
    logic [DW-1:0] push_data;
    logic          full;
    logic          pop;
    logic          accept;
    logic          drop;

    // eoc_q resets high so an eoc already asserted at reset release is not an edge.
    assign capture = en & eoc & ~eoc_q;

`ifdef ADC_AVG_EN
    logic [DW+AVG_LOG2-1:0] acc_q, acc_d, acc_sum;
    logic [AVG_LOG2-1:0]    cnt_q, cnt_d;

    assign acc_sum = acc_q + (DW+AVG_LOG2)'(din);

    always_comb begin
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        push      = 1'b0;
        push_data = acc_sum[DW+AVG_LOG2-1:AVG_LOG2];
        if (!en) begin
            acc_d = '0;
            cnt_d = '0;
        end else if (capture) begin
            if (&cnt_q) begin
                push  = 1'b1;
                acc_d = '0;
                cnt_d = '0;
            end else begin
                acc_d = acc_sum;
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q <= '0;
            cnt_q <= '0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
        end
    end
`else
    // Block size only matters when averaging is built in.
    localparam int unused_avg_log2 = AVG_LOG2;

    assign push      = capture;
    assign push_data = din;
`endif

    // Stream handshake: a result transfers on a clk edge where m_valid & m_ready are
    // both high; m_valid never depends on m_ready, and m_data holds while m_valid & !m_ready.
    assign m_valid  = (level_q != '0);
    assign m_data   = m_valid ? mem[rd_ptr_q] : '0;
    assign level    = level_q;
    assign overflow = overflow_q;

    assign full   = (level_q == (AW+1)'(DEPTH));
    assign pop    = m_valid & m_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    assign accept = push & (~full | pop);
    assign drop   = push & full & ~pop;

    always_comb begin
        wr_ptr_d   = accept ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d   = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        overflow_d = drop | (overflow_q & ~clr_ovf);
        level_d    = level_q;
        case ({accept, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
            eoc_q      <= 1'b1;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            overflow_q <= overflow_d;
            eoc_q      <= eoc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && accept) begin
            mem[wr_ptr_q] <= push_data;
        end
    end

endmodule
